// File: rtl/rv_bus_pkg.sv
// Shared definitions for the peripheral bus: FSM state encoding, base address default and a
// constant-safe clog2 used to size the slave index.
package rv_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/rv_bus_decode.sv
// Combinational address decode: region hit, slave index, window offset and request legality.
// Kept separate so a future multi-master arbiter can reuse it per master port.
module rv_bus_decode
  import rv_bus_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              N_SLV     = 4,
  parameter int              SLV_AW    = 12,
  parameter int              IDX_W     = 2,
  parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(DEFAULT_BASE_ADDR)
) (
  input  logic [XLEN-1:0]   addr,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic [SLV_AW-1:0] offset,
  output logic              illegal
);

  localparam int TAG_LSB = SLV_AW + IDX_W;

  logic in_range;

  assign idx    = addr[SLV_AW +: IDX_W];
  assign offset = addr[SLV_AW-1:0];

  // A power-of-two slave count fills the whole index field, so every index is populated.
  generate
    if (N_SLV == (1 << IDX_W)) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_partial
      assign in_range = (int'(idx) < N_SLV);
    end
  endgenerate

  assign hit     = (addr[XLEN-1:TAG_LSB] == BASE_ADDR[XLEN-1:TAG_LSB]) && in_range;
  assign illegal = (offset[1:0] != 2'b00) || (wr_en && rd_en);

endmodule

// File: rtl/rv_periph_bus.sv
// Peripheral interconnect: rv_core data port to N_SLV memory-mapped slaves with a registered
// request/ready handshake, wait-state timeout and a single-cycle response to the master.
module rv_periph_bus
  import rv_bus_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              N_SLV     = 4,
  parameter int              SLV_AW    = 12,
  parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(DEFAULT_BASE_ADDR),
  parameter int              TIMEOUT   = 255,
  parameter int              TO_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XLEN-1:0]       m_addr,
  input  logic [XLEN-1:0]       m_wr_data,
  input  logic                  m_wr_en,
  input  logic                  m_rd_en,
  output logic [XLEN-1:0]       m_rd_data,
  output logic                  m_ready,
  output logic                  m_err,
  output logic [N_SLV-1:0]      s_sel,
  output logic [SLV_AW-1:0]     s_addr,
  output logic [XLEN-1:0]       s_wr_data,
  output logic                  s_wr_en,
  output logic                  s_rd_en,
  input  logic [N_SLV*XLEN-1:0] s_rd_data,
  input  logic [N_SLV-1:0]      s_ready
);

  localparam int IDX_W = (N_SLV > 1) ? clog2(N_SLV) : 1;

  bus_state_e        state, state_n;
  logic [TO_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]  sel_idx, sel_idx_n;
  logic [N_SLV-1:0]  s_sel_n;
  logic [SLV_AW-1:0] s_addr_n;
  logic [XLEN-1:0]   s_wr_data_n, m_rd_data_n;
  logic              s_wr_en_n, s_rd_en_n, m_ready_n, m_err_n;

  logic              dec_hit, dec_illegal;
  logic [IDX_W-1:0]  dec_idx;
  logic [SLV_AW-1:0] dec_offset;

  rv_bus_decode #(
    .XLEN      (XLEN),
    .N_SLV     (N_SLV),
    .SLV_AW    (SLV_AW),
    .IDX_W     (IDX_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .addr    (m_addr),
    .wr_en   (m_wr_en),
    .rd_en   (m_rd_en),
    .hit     (dec_hit),
    .idx     (dec_idx),
    .offset  (dec_offset),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sel_idx_n   = sel_idx;
    s_sel_n     = s_sel;
    s_addr_n    = s_addr;
    s_wr_data_n = s_wr_data;
    s_wr_en_n   = s_wr_en;
    s_rd_en_n   = s_rd_en;
    m_rd_data_n = '0;
    m_ready_n   = 1'b0;
    m_err_n     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (m_wr_en || m_rd_en) begin
          if (dec_hit && !dec_illegal) begin
            state_n     = ST_ACCESS;
            cnt_n       = '0;
            sel_idx_n   = dec_idx;
            s_sel_n     = N_SLV'(1) << dec_idx;
            s_addr_n    = dec_offset;
            s_wr_data_n = m_wr_data;
            s_wr_en_n   = m_wr_en;
            s_rd_en_n   = m_rd_en;
          end else begin
            // Miss or illegal request: answer straight away without touching any slave.
            state_n   = ST_RESP;
            m_ready_n = 1'b1;
            m_err_n   = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        // Ready is tested before the timeout so a slave answering on the last cycle still wins.
        if (s_ready[sel_idx]) begin
          state_n     = ST_RESP;
          m_ready_n   = 1'b1;
          m_rd_data_n = s_rd_en ? s_rd_data[sel_idx*XLEN +: XLEN] : '0;
          s_sel_n     = '0;
          s_wr_en_n   = 1'b0;
          s_rd_en_n   = 1'b0;
        end else if (cnt == TO_W'(TIMEOUT)) begin
          state_n   = ST_RESP;
          m_ready_n = 1'b1;
          m_err_n   = 1'b1;
          s_sel_n   = '0;
          s_wr_en_n = 1'b0;
          s_rd_en_n = 1'b0;
        end else begin
          cnt_n = cnt + TO_W'(1);
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sel_idx   <= '0;
      s_sel     <= '0;
      s_addr    <= '0;
      s_wr_data <= '0;
      s_wr_en   <= 1'b0;
      s_rd_en   <= 1'b0;
      m_rd_data <= '0;
      m_ready   <= 1'b0;
      m_err     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sel_idx   <= sel_idx_n;
      s_sel     <= s_sel_n;
      s_addr    <= s_addr_n;
      s_wr_data <= s_wr_data_n;
      s_wr_en   <= s_wr_en_n;
      s_rd_en   <= s_rd_en_n;
      m_rd_data <= m_rd_data_n;
      m_ready   <= m_ready_n;
      m_err     <= m_err_n;
    end
  end

endmodule
